// File: rtl/rot_result_queue.sv
// Rotate-unit result queue: in-order circular FIFO between the rotate pipeline and the CDB.
// Optional same-cycle bypass of an empty queue is enabled by defining ROT_RESULT_BYPASS_EN.

package rot_result_pkg;
    // CR0 field (lt, gt, eq, so) plus the XER bits a rotate/shift can update.
    typedef struct packed {
        logic [3:0] cr0;
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;
endpackage

module rot_result_queue
    import rot_result_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic [RS_ID_WIDTH-1:0]   rs_id_in,
    input  logic [4:0]               result_reg_addr_in,
    input  logic [31:0]              result_in,
    input  cond_exception_t          cr0_xer_in,
    output logic                     cdb_request,
    input  logic                     cdb_grant,
    output logic [RS_ID_WIDTH-1:0]   cdb_rs_id,
    output logic [4:0]               cdb_reg_addr,
    output logic [31:0]              cdb_result,
    output cond_exception_t          cdb_cr0_xer,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // result is carried in IBM bit order: bit 0 (the MSB) lives at [31] here.
    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             reg_addr;
        logic [31:0]            result;
        cond_exception_t        cr0_xer;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    entry_t          entry_in;
    entry_t          head;
    entry_t          out_entry;
    logic            empty;
    logic            full;
    logic            push_en;
    logic            pop_en;

    assign entry_in = '{rs_id:    rs_id_in,
                        reg_addr: result_reg_addr_in,
                        result:   result_in,
                        cr0_xer:  cr0_xer_in};

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Ready ignores a same-cycle pop so it stays a pure function of registered state.
    assign input_ready = !full;

`ifdef ROT_RESULT_BYPASS_EN
    logic bypass_take;

    assign bypass_take = empty && input_valid && cdb_grant;
    assign cdb_request = !empty || input_valid;
    assign out_entry   = empty ? entry_in : head;
    assign push_en     = input_valid && input_ready && !bypass_take;
`else
    assign cdb_request = !empty;
    assign out_entry   = head;
    assign push_en     = input_valid && input_ready;
`endif

    // Only a queued head can be popped; a bypassed result never touches the pointers.
    assign pop_en = cdb_grant && !empty;

    assign cdb_rs_id    = out_entry.rs_id;
    assign cdb_reg_addr = out_entry.reg_addr;
    assign cdb_result   = out_entry.result;
    assign cdb_cr0_xer  = out_entry.cr0_xer;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
    end

endmodule

// File: tb/tb_rot_result_queue.sv
// Directed bench for rot_result_queue: vector table for fill/drain/full corners plus
// hand-written sequences for streaming, asynchronous reset and (when enabled) bypass.

module tb_rot_result_queue;
    import rot_result_pkg::*;

    localparam int RS_W  = 5;
    localparam int DEPTH = 4;
`ifdef ROT_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              input_valid;
    logic              input_ready;
    logic [RS_W-1:0]   rs_id_in;
    logic [4:0]        result_reg_addr_in;
    logic [31:0]       result_in;
    cond_exception_t   cr0_xer_in;
    logic              cdb_request;
    logic              cdb_grant;
    logic [RS_W-1:0]   cdb_rs_id;
    logic [4:0]        cdb_reg_addr;
    logic [31:0]       cdb_result;
    cond_exception_t   cdb_cr0_xer;
    logic [2:0]        level;

    int total = 0;
    int bad   = 0;

    rot_result_queue #(.RS_ID_WIDTH(RS_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_valid        (input_valid),
        .input_ready        (input_ready),
        .rs_id_in           (rs_id_in),
        .result_reg_addr_in (result_reg_addr_in),
        .result_in          (result_in),
        .cr0_xer_in         (cr0_xer_in),
        .cdb_request        (cdb_request),
        .cdb_grant          (cdb_grant),
        .cdb_rs_id          (cdb_rs_id),
        .cdb_reg_addr       (cdb_reg_addr),
        .cdb_result         (cdb_result),
        .cdb_cr0_xer        (cdb_cr0_xer),
        .level              (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Payload of a result is derived from its id so every field can be predicted.
    function automatic logic [31:0] res_of(input int id);
        return 32'hC0DE_0000 + 32'(id) * 32'h0000_1111;
    endfunction
    function automatic logic [4:0] reg_of(input int id);
        return 5'(31 - id);
    endfunction
    function automatic logic [6:0] cr_of(input int id);
        return 7'(id * 3);
    endfunction

    typedef struct {
        logic       v;
        logic       g;
        int         id;
        logic       exp_ready;
        logic       exp_req;
        int         exp_level;
        logic       chk_head;
        int         exp_id;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic g, input int id,
                                input logic rdy, input logic req, input int lvl,
                                input logic chk, input int hid);
        vec_t r;
        r.v = v; r.g = g; r.id = id;
        r.exp_ready = rdy; r.exp_req = req; r.exp_level = lvl;
        r.chk_head = chk; r.exp_id = hid;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic g, input int id);
        input_valid        = v;
        cdb_grant          = g;
        rs_id_in           = RS_W'(id);
        result_reg_addr_in = reg_of(id);
        result_in          = res_of(id);
        cr0_xer_in         = cond_exception_t'(cr_of(id));
    endtask

    task automatic check_head(input string tag, input int id);
        check({tag, " rs_id"},  32'(cdb_rs_id),    32'(id));
        check({tag, " reg"},    32'(cdb_reg_addr), 32'(reg_of(id)));
        check({tag, " result"}, cdb_result,        res_of(id));
        check({tag, " cr0xer"}, 32'(cdb_cr0_xer),  32'(cr_of(id)));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        // Fill with grant low, reject a 5th push, pop+push collision while full, drain in order.
        vecs[0]  = mk(1, 0, 1, 1, BYP, 0, 0, 0);
        vecs[1]  = mk(1, 0, 2, 1, 1,   1, 1, 1);
        vecs[2]  = mk(1, 0, 3, 1, 1,   2, 1, 1);
        vecs[3]  = mk(1, 0, 4, 1, 1,   3, 1, 1);
        vecs[4]  = mk(1, 0, 5, 0, 1,   4, 1, 1);
        vecs[5]  = mk(1, 1, 5, 0, 1,   4, 1, 1);
        vecs[6]  = mk(1, 0, 5, 1, 1,   3, 1, 2);
        vecs[7]  = mk(0, 1, 0, 0, 1,   4, 1, 2);
        vecs[8]  = mk(0, 1, 0, 1, 1,   3, 1, 3);
        vecs[9]  = mk(0, 1, 0, 1, 1,   2, 1, 4);
        vecs[10] = mk(0, 1, 0, 1, 1,   1, 1, 5);
        vecs[11] = mk(0, 1, 0, 1, 0,   0, 0, 0);
        vecs[12] = mk(0, 0, 0, 1, 0,   0, 0, 0);

        rst = 1'b0;
        drive(0, 0, 0);
        #12;
        check("reset ready", 32'(input_ready), 32'd1);
        check("reset req",   32'(cdb_request), 32'd0);
        check("reset level", 32'(level),       32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

`ifndef ROT_RESULT_BYPASS_EN
        // Grant held high while the queue is empty must be ignored; the entry appears next cycle.
        drive(1, 1, 3);
        result_reg_addr_in = 5'd7;
        result_in          = 32'hDEAD_BEEF;
        @(negedge clk);
        check("first req before edge", 32'(cdb_request), 32'd0);
        next_cycle();
        drive(0, 1, 0);
        @(negedge clk);
        check("first req",    32'(cdb_request),  32'd1);
        check("first rs_id",  32'(cdb_rs_id),    32'd3);
        check("first reg",    32'(cdb_reg_addr), 32'd7);
        check("first result", cdb_result,        32'hDEAD_BEEF);
        check("first level",  32'(level),        32'd1);
        next_cycle();
        drive(0, 0, 0);
        @(negedge clk);
        check("first level after pop", 32'(level),       32'd0);
        check("first req after pop",   32'(cdb_request), 32'd0);
        next_cycle();
`else
        // Empty queue, valid and grant together: consumed combinationally, never queued.
        drive(1, 1, 0);
        result_in = 32'h1234_5678;
        @(negedge clk);
        check("byp req",    32'(cdb_request), 32'd1);
        check("byp result", cdb_result,       32'h1234_5678);
        check("byp level",  32'(level),       32'd0);
        next_cycle();
        drive(0, 0, 0);
        @(negedge clk);
        check("byp level after", 32'(level),       32'd0);
        check("byp req after",   32'(cdb_request), 32'd0);
        next_cycle();
        // Not granted: the bypassed result is written normally and stays at the head.
        drive(1, 0, 9);
        @(negedge clk);
        check_head("byp nogrant same", 9);
        next_cycle();
        drive(0, 1, 0);
        @(negedge clk);
        check("byp nogrant level", 32'(level), 32'd1);
        check_head("byp nogrant queued", 9);
        next_cycle();
        drive(0, 0, 0);
        next_cycle();
`endif

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].g, vecs[i].id);
            @(negedge clk);
            check($sformatf("vec%0d ready", i), 32'(input_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d req", i),   32'(cdb_request), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d level", i), 32'(level),       32'(vecs[i].exp_level));
            if (vecs[i].chk_head)
                check_head($sformatf("vec%0d head", i), vecs[i].exp_id);
            next_cycle();
        end

        // Streaming: one push and one pop every cycle, pointers wrap several times.
        drive(1, 0, 10);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 11 + k);
            @(negedge clk);
            check($sformatf("stream%0d level", k), 32'(level), 32'd1);
            check_head($sformatf("stream%0d head", k), 10 + k);
            next_cycle();
        end
        drive(0, 1, 0);
        @(negedge clk);
        check_head("stream tail", 30);
        next_cycle();
        drive(0, 0, 0);
        @(negedge clk);
        check("stream empty level", 32'(level), 32'd0);
        next_cycle();

        // Asynchronous reset mid-cycle with three entries queued.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 20 + k);
            next_cycle();
        end
        drive(0, 0, 0);
        @(negedge clk);
        check("pre-reset level", 32'(level), 32'd3);
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("async rst req",   32'(cdb_request), 32'd0);
        check("async rst level", 32'(level),       32'd0);
        check("async rst ready", 32'(input_ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("post-reset level", 32'(level),       32'd0);
        check("post-reset req",   32'(cdb_request), 32'd0);
        next_cycle();
        drive(1, 0, 23);
        next_cycle();
        drive(0, 0, 0);
        @(negedge clk);
        check("fresh level", 32'(level), 32'd1);
        check_head("fresh head", 23);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
